// File: rtl/bram_port_server.sv
// bram_port_server
// Requester-side controller for one port of a dual-port BRAM. Requests come
// in on a valid/ready handshake and go straight out on the BRAM port pins.
// Read data is captured from DO after the fixed BRAM latency and buffered in
// a small response FIFO. Reads are admitted only while a FIFO slot is
// guaranteed for them, so a stalled consumer can never cause data loss.
//
// Optional build macro: BRAM_PORT_SERVER_BYPASS_EN
//   When defined, read data arriving at an empty FIFO is presented on
//   RESP_DATA in the same cycle, and is only stored if the consumer does not
//   take it right away. Read latency drops from L+1 to L cycles.

module bram_port_server #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  // request channel
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  // response channel
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  // BRAM port
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  // Read latency of the attached BRAM: one cycle, plus the optional DO register.
  localparam int LAT   = 1 + PIPELINED;
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for every read in the pipe plus a full FIFO, with headroom.
  localparam int OUT_W = $clog2(RESP_DEPTH + LAT + 1) + 1;

  logic                  fire;
  logic                  rd_fire;
  logic                  arrive;
  logic                  push;
  logic                  pop;
  logic                  fifo_nonempty;
  logic                  fifo_full;
  logic                  credit_ok;

  logic [LAT-1:0]        rd_pipe_q;
  logic [LAT-1:0]        rd_pipe_d;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

  logic [OUT_W-1:0]      pipe_cnt;
  logic [OUT_W-1:0]      outstanding;

  // Credit count: every read in the BRAM pipe plus every buffered entry. Both
  // terms are registered, so RESP_READY never reaches REQ_READY combinationally;
  // a pop therefore only frees its slot on the following cycle.
  always_comb begin
    pipe_cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      pipe_cnt = pipe_cnt + OUT_W'(rd_pipe_q[i]);
    end
    outstanding = pipe_cnt + OUT_W'(count_q);
    credit_ok   = (outstanding < OUT_W'(RESP_DEPTH));
  end

  // Request handshake and BRAM port drive. Writes take no credit but are held
  // back with reads whenever credits run out, which keeps request order intact.
  always_comb begin
    REQ_READY = !RST && credit_ok;
    fire      = REQ_VALID && REQ_READY;
    rd_fire   = fire && !REQ_WRITE;
    BRAM_EN   = fire;
    BRAM_WE   = fire && REQ_WRITE;
    BRAM_ADDR = REQ_ADDR;
    BRAM_DI   = REQ_DATA;
  end

  // Read tracking: a token enters stage 0 on each accepted read and reaches the
  // last stage exactly when BRAM_DO carries that read's data.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_fire;
    for (int i = 1; i < LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    arrive = rd_pipe_q[LAT-1];
  end

  // Response side: FIFO head presentation, push/pop decisions, optional bypass.
  always_comb begin
    fifo_nonempty = (count_q != '0);
    fifo_full     = (count_q == CNT_W'(RESP_DEPTH));
    pop           = fifo_nonempty && RESP_READY;
`ifdef BRAM_PORT_SERVER_BYPASS_EN
    // An empty FIFO lets arriving data through directly; it is stored only if
    // the consumer leaves it on the table this cycle.
    RESP_VALID = fifo_nonempty || arrive;
    RESP_DATA  = fifo_nonempty ? mem_q[rd_ptr_q] : BRAM_DO;
    push       = arrive && !(!fifo_nonempty && RESP_READY);
`else
    RESP_VALID = fifo_nonempty;
    RESP_DATA  = mem_q[rd_ptr_q];
    push       = arrive;
`endif
  end

  // FIFO pointer and occupancy next-state; simultaneous push and pop leaves the
  // count alone while both pointers step.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset drops any in-flight reads and buffered data at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pipe_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= BRAM_DO;
    end
  end

  // Credit admission guarantees a free slot for every arriving read.
  a_no_push_when_full : assert property (
    @(posedge CLK) disable iff (RST) !(push && fifo_full)
  );

  // A pop is only ever issued against a stored entry.
  a_no_pop_when_empty : assert property (
    @(posedge CLK) disable iff (RST) !(pop && !fifo_nonempty)
  );

  // Reads in flight plus buffered entries never exceed the FIFO capacity.
  a_credit_bound : assert property (
    @(posedge CLK) disable iff (RST) (outstanding <= OUT_W'(RESP_DEPTH))
  );

  // Occupancy can never run past the number of slots.
  a_count_bound : assert property (
    @(posedge CLK) disable iff (RST) (count_q <= CNT_W'(RESP_DEPTH))
  );

endmodule

// File: tb/tb_bram_port_server.sv
// Bench for bram_port_server: two instances (PIPELINED=0 and PIPELINED=1),
// each attached to its own behavioural BRAM. Reads push their expected data
// into a per-port scoreboard queue at accept time; a monitor pops and compares
// whenever a response is taken.

module tb_bram_port_server;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DEPTH = 4;
`ifdef BRAM_PORT_SERVER_BYPASS_EN
  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
`else
  localparam int LAT0 = 2;
  localparam int LAT1 = 3;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] cyc;
    logic        lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic [1:0]         req_valid;
  logic [1:0]         req_write;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_data;
  logic [1:0]         resp_ready;

  wire  [1:0]         req_ready;
  wire  [1:0]         resp_valid;
  wire  [1:0][DW-1:0] resp_data;
  wire  [1:0]         bram_en;
  wire  [1:0]         bram_we;
  wire  [1:0][AW-1:0] bram_addr;
  wire  [1:0][DW-1:0] bram_di;
  wire  [1:0][DW-1:0] bram_do;

  logic [DW-1:0] mem [2][256];
  logic [1:0][DW-1:0] do_r;
  logic [1:0][DW-1:0] do_p;
  logic init_done = 1'b0;

  logic [DW-1:0] shadow [2][256];
  exp_t q0 [$];
  exp_t q1 [$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_server #(.PIPELINED(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) u_dut0 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]), .REQ_WRITE(req_write[0]),
    .REQ_ADDR(req_addr[0]), .REQ_DATA(req_data[0]),
    .RESP_VALID(resp_valid[0]), .RESP_READY(resp_ready[0]), .RESP_DATA(resp_data[0]),
    .BRAM_EN(bram_en[0]), .BRAM_WE(bram_we[0]), .BRAM_ADDR(bram_addr[0]),
    .BRAM_DI(bram_di[0]), .BRAM_DO(bram_do[0])
  );

  bram_port_server #(.PIPELINED(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(DEPTH)) u_dut1 (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]), .REQ_WRITE(req_write[1]),
    .REQ_ADDR(req_addr[1]), .REQ_DATA(req_data[1]),
    .RESP_VALID(resp_valid[1]), .RESP_READY(resp_ready[1]), .RESP_DATA(resp_data[1]),
    .BRAM_EN(bram_en[1]), .BRAM_WE(bram_we[1]), .BRAM_ADDR(bram_addr[1]),
    .BRAM_DI(bram_di[1]), .BRAM_DO(bram_do[1])
  );

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  // Behavioural write-first BRAM; port 1 has the extra DO register.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int d = 0; d < 2; d++)
        for (int a = 0; a < 256; a++) mem[d][a] <= pat(a[7:0]);
      init_done <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (bram_en[d]) begin
          if (bram_we[d]) begin
            mem[d][bram_addr[d]] <= bram_di[d];
            do_r[d] <= bram_di[d];
          end else begin
            do_r[d] <= mem[d][bram_addr[d]];
          end
        end
        do_p[d] <= do_r[d];
      end
    end
  end

  assign bram_do[0] = do_r[0];
  assign bram_do[1] = do_p[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input logic [7:0] data, input bit lat);
    exp_t e;
    e.data = data;
    e.cyc  = cyc;
    e.lat  = lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_port(input int d);
    exp_t e;
    int   qs;
    int   lexp;
    qs   = (d == 0) ? q0.size() : q1.size();
    lexp = (d == 0) ? LAT0 : LAT1;
    if (qs == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_resp port %0d: got data %0h, required no response", d, resp_data[d]);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("resp_data p%0d", d), {24'd0, resp_data[d]}, {24'd0, e.data});
      if (e.lat) check($sformatf("resp_latency p%0d", d), cyc - int'(e.cyc), lexp);
    end
  endtask

  // Monitor: compare every response the consumer takes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++)
          if (resp_valid[d] && resp_ready[d]) mon_port(d);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request; on accept, check the BRAM pins and log the expectation.
  task automatic issue(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic [7:0] exp, input bit lat, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_data[d]  = data;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        ok = 1;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    if (ok) begin
      check("bram_en", {31'd0, bram_en[d]}, 32'd1);
      check("bram_we", {31'd0, bram_we[d]}, {31'd0, wr});
      check("bram_addr", {24'd0, bram_addr[d]}, {24'd0, addr});
      if (wr) begin
        check("bram_di", {24'd0, bram_di[d]}, {24'd0, data});
        shadow[d][addr] = data;
      end else begin
        push_exp(d, exp, lat);
      end
      @(posedge clk);
      #1;
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    req_valid[d] = 1'b0;
    req_write[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w;
    bit  done;
    logic [7:0] a;

    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) shadow[d][i] = pat(i[7:0]);

    // Reset: requests presented during reset must not reach the BRAM.
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    check("rst_bram_en", {30'd0, bram_en}, 32'd0);
    check("rst_bram_we", {30'd0, bram_we}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {30'd0, req_ready}, 32'd3);
    @(posedge clk);
    #1;

    // Port 0 (L=1): write then read back, one-cycle WE pulse, read-before-write order.
    resp_ready = 2'b11;
    issue(0, 1, 8'd3, 8'hA5, 8'h00, 0, w);
    @(negedge clk);
    check("we_pulse_end", {31'd0, bram_we[0]}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 8'd3, 8'h00, 8'hA5, 1, w);
`ifdef BRAM_PORT_SERVER_BYPASS_EN
    @(negedge clk);
    check("bypass_count_c1", {29'd0, u_dut0.count_q}, 32'd0);
    @(negedge clk);
    check("bypass_count_c2", {29'd0, u_dut0.count_q}, 32'd0);
    @(posedge clk);
    #1;
`endif
    idle(3);
    issue(0, 0, 8'd3, 8'h00, 8'hA5, 1, w);
    issue(0, 1, 8'd3, 8'h5A, 8'h00, 0, w);
    issue(0, 0, 8'd3, 8'h00, 8'h5A, 1, w);
    idle(6);
    check("drain_p0_a", q0.size(), 0);

    // Port 1 (L=2): preload 0..7, then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) issue(1, 1, i[7:0], 8'h10 + i[7:0], 8'h00, 0, w);
    for (int i = 0; i < 8; i++) begin
      issue(1, 0, i[7:0], 8'h00, 8'h10 + i[7:0], 1, w);
      check("b2b_ready", w, 0);
    end
    idle(8);
    check("drain_p1_b", q1.size(), 0);

    // Port 0 credit limit: consumer stalled, only 4 reads get in.
    resp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 8'd8 + i[7:0], 8'h00, pat(8'd8 + i[7:0]), 0, w);
      check("credit_accept", w, 0);
    end
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 8'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("credit_stall", {31'd0, req_ready[0]}, 32'd0);
      check("credit_stall_en", {31'd0, bram_en[0]}, 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("pop_cycle_valid", {31'd0, resp_valid[0]}, 32'd1);
    check("pop_cycle_ready", {31'd0, req_ready[0]}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, 0, 8'd12, 8'h00, pat(8'd12), 0, w);
    check("ready_after_pop", w, 0);
    issue(0, 0, 8'd13, 8'h00, pat(8'd13), 0, w);
    idle(8);
    check("drain_p0_c", q0.size(), 0);

    // Port 1: 20 random reads against a randomly stalling consumer.
    done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a = 8'($urandom_range(0, 255));
          issue(1, 0, a, 8'h00, shadow[1][a], 0, w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          resp_ready[1] = 1'($urandom_range(0, 1));
        end
      end
    join
    resp_ready[1] = 1'b1;
    idle(12);
    check("drain_p1_rand", q1.size(), 0);

    // Port 1: reset with one buffered read and two in flight.
    resp_ready[1] = 1'b0;
    issue(1, 0, 8'd20, 8'h00, 8'h00, 0, w);
    issue(1, 0, 8'd21, 8'h00, 8'h00, 0, w);
    issue(1, 0, 8'd22, 8'h00, 8'h00, 0, w);
    check("pre_rst_valid", {31'd0, resp_valid[1]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_valid_now", {31'd0, resp_valid[1]}, 32'd0);
    check("rst_ready_now", {31'd0, req_ready[1]}, 32'd0);
    q1.delete();
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_resp", {30'd0, resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1, 0, 8'd5, 8'h00, 8'h15, 1, w);
    idle(6);
    check("drain_p1_e", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
